ad9516_cfg_seq: RTL and testbench

AD9516_CFG_SEQ -- requirements
Module: ad9516_cfg_seq

---
 rtl/ad9516_cfg_seq.sv | 180 ++++++++++++++++++
 tb/tb_ad9516_cfg_seq.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/ad9516_cfg_seq.sv
// AD9516 configuration sequencer: power-up delay, SPI write launch/handshake,
// PLL lock qualification with bounded retries, and lock-loss supervision.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | waiting for a configuration request
// PWR_WAIT  | power-up / settle delay before launching the SPI write
// START     | start level raised toward the SPI write wrapper
// WAIT_BUSY | start held, waiting for the wrapper to report busy
// WRITING   | wrapper busy, waiting for the write to finish
// LOCK_WAIT | qualifying PLL lock for LOCK_STABLE consecutive cycles
// DONE      | configured and locked, supervising lock
// ERROR     | retries exhausted, waiting for a new request
module ad9516_cfg_seq #(
    parameter int unsigned  AUTO_START   = 1,
    parameter logic [31:0]  POWERUP_DLY  = 32'd100000,
    parameter logic [31:0]  ACK_TIMEOUT  = 32'd1000,
    parameter logic [31:0]  LOCK_TIMEOUT = 32'd500000,
    parameter logic [31:0]  LOCK_STABLE  = 32'd1000,
    parameter logic [3:0]   MAX_RETRY    = 4'd3
) (
    input  logic       sys_clk_i,
    input  logic       rst_i,
    input  logic       cfg_req_i,
    input  logic       write_busy_i,
    input  logic       pll_ld_i,
    output logic       spi_write_start_o,
    output logic       cfg_done_o,
    output logic       cfg_err_o,
    output logic       lock_lost_o,
    output logic [3:0] retry_cnt_o,
    output logic [2:0] state_o
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_PWR_WAIT  = 3'd1;
    localparam logic [2:0] S_START     = 3'd2;
    localparam logic [2:0] S_WAIT_BUSY = 3'd3;
    localparam logic [2:0] S_WRITING   = 3'd4;
    localparam logic [2:0] S_LOCK_WAIT = 3'd5;
    localparam logic [2:0] S_DONE      = 3'd6;
    localparam logic [2:0] S_ERROR     = 3'd7;

    logic [2:0]  state, state_nxt;
    logic [31:0] timer, timer_nxt, timer_inc;
    logic [31:0] stable, stable_nxt, stable_inc;
    logic [3:0]  retry_cnt, retry_nxt;
    logic        lost_nxt;
    logic        ld_meta, lock_s;
    logic        req_q, req_q2, req_rise;
    logic        pwr_tc, ack_tc, lock_tc, stable_reach, retry_path;

    assign req_rise   = req_q & ~req_q2;
    assign timer_inc  = (timer == '1) ? timer : timer + 32'd1;
    assign stable_inc = (stable == '1) ? stable : stable + 32'd1;

    // Terminal compares in 33 bits so a zero limit cannot underflow.
    assign pwr_tc       = ({1'b0, timer} + 33'd1) >= {1'b0, POWERUP_DLY};
    assign ack_tc       = ({1'b0, timer} + 33'd1) >= {1'b0, ACK_TIMEOUT};
    assign lock_tc      = ({1'b0, timer} + 33'd1) >= {1'b0, LOCK_TIMEOUT};
    assign stable_reach = lock_s && (({1'b0, stable} + 33'd1) >= {1'b0, LOCK_STABLE});

    always_comb begin
        state_nxt  = state;
        timer_nxt  = timer;
        stable_nxt = stable;
        retry_nxt  = retry_cnt;
        lost_nxt   = 1'b0;
        retry_path = 1'b0;
        case (state)
            S_IDLE, S_ERROR: begin
                if (req_rise) begin
                    state_nxt  = S_PWR_WAIT;
                    timer_nxt  = '0;
                    stable_nxt = '0;
                    retry_nxt  = '0;
                end
            end
            S_PWR_WAIT: begin
                if (pwr_tc) begin
                    state_nxt = S_START;
                    timer_nxt = '0;
                end else begin
                    timer_nxt = timer_inc;
                end
            end
            S_START: begin
                state_nxt = S_WAIT_BUSY;
                timer_nxt = '0;
            end
            S_WAIT_BUSY: begin
                if (write_busy_i) begin
                    state_nxt = S_WRITING;
                    timer_nxt = '0;
                end else if (ack_tc) begin
                    retry_path = 1'b1;
                end else begin
                    timer_nxt = timer_inc;
                end
            end
            S_WRITING: begin
                if (!write_busy_i) begin
                    state_nxt  = S_LOCK_WAIT;
                    timer_nxt  = '0;
                    stable_nxt = '0;
                end
            end
            S_LOCK_WAIT: begin
                stable_nxt = lock_s ? stable_inc : '0;
                if (stable_reach) begin
                    state_nxt = S_DONE;
                end else if (lock_tc) begin
                    retry_path = 1'b1;
                end else begin
                    timer_nxt = timer_inc;
                end
            end
            S_DONE: begin
                // A fresh request outranks lock loss; lock loss only requalifies.
                if (req_rise) begin
                    state_nxt  = S_PWR_WAIT;
                    timer_nxt  = '0;
                    stable_nxt = '0;
                    retry_nxt  = '0;
                end else if (!lock_s) begin
                    state_nxt  = S_LOCK_WAIT;
                    timer_nxt  = '0;
                    stable_nxt = '0;
                    lost_nxt   = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        if (retry_path) begin
            timer_nxt  = '0;
            stable_nxt = '0;
            if (retry_cnt < MAX_RETRY) begin
                retry_nxt = retry_cnt + 4'd1;
                state_nxt = S_PWR_WAIT;
            end else begin
                state_nxt = S_ERROR;
            end
        end
    end

    always_ff @(posedge sys_clk_i) begin
        if (rst_i) begin
            state             <= (AUTO_START != 0) ? S_PWR_WAIT : S_IDLE;
            timer             <= '0;
            stable            <= '0;
            retry_cnt         <= '0;
            ld_meta           <= 1'b0;
            lock_s            <= 1'b0;
            req_q             <= 1'b0;
            req_q2            <= 1'b0;
            spi_write_start_o <= 1'b0;
            cfg_done_o        <= 1'b0;
            cfg_err_o         <= 1'b0;
            lock_lost_o       <= 1'b0;
        end else begin
            state             <= state_nxt;
            timer             <= timer_nxt;
            stable            <= stable_nxt;
            retry_cnt         <= retry_nxt;
            ld_meta           <= pll_ld_i;
            lock_s            <= ld_meta;
            req_q             <= cfg_req_i;
            req_q2            <= req_q;
            spi_write_start_o <= (state_nxt == S_START) || (state_nxt == S_WAIT_BUSY);
            cfg_done_o        <= (state_nxt == S_DONE);
            cfg_err_o         <= (state_nxt == S_ERROR);
            lock_lost_o       <= lost_nxt;
        end
    end

    assign retry_cnt_o = retry_cnt;
    assign state_o     = state;

endmodule

// File: tb/tb_ad9516_cfg_seq.sv
// Directed bench for ad9516_cfg_seq: nominal bring-up, ack timeout, lock glitch,
// lock timeout with retry, lock loss, re-request and reset during a write.
module tb_ad9516_cfg_seq;

    logic       clk = 1'b0;
    logic       rst_i;
    logic       cfg_req_i;
    logic       write_busy_i;
    logic       pll_ld_i;
    logic       spi_write_start_o;
    logic       cfg_done_o;
    logic       cfg_err_o;
    logic       lock_lost_o;
    logic [3:0] retry_cnt_o;
    logic [2:0] state_o;

    int vectors = 0;
    int miscompares = 0;
    int start_rises = 0;
    logic start_prev = 1'b0;

    ad9516_cfg_seq #(
        .AUTO_START   (1),
        .POWERUP_DLY  (32'd10),
        .ACK_TIMEOUT  (32'd8),
        .LOCK_TIMEOUT (32'd50),
        .LOCK_STABLE  (32'd4),
        .MAX_RETRY    (4'd2)
    ) dut (
        .sys_clk_i         (clk),
        .rst_i             (rst_i),
        .cfg_req_i         (cfg_req_i),
        .write_busy_i      (write_busy_i),
        .pll_ld_i          (pll_ld_i),
        .spi_write_start_o (spi_write_start_o),
        .cfg_done_o        (cfg_done_o),
        .cfg_err_o         (cfg_err_o),
        .lock_lost_o       (lock_lost_o),
        .retry_cnt_o       (retry_cnt_o),
        .state_o           (state_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        start_prev <= spi_write_start_o;
        if (spi_write_start_o && !start_prev) start_rises <= start_rises + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Entered right after the START edge; returns on the LOCK_WAIT entry edge.
    task automatic ack_write(input int hold);
        tick();
        chk("wb_state", 32'(state_o), 3);
        chk("wb_start", 32'(spi_write_start_o), 1);
        tick();
        write_busy_i = 1'b1;
        tick();
        chk("wr_state", 32'(state_o), 4);
        chk("wr_start", 32'(spi_write_start_o), 0);
        repeat (hold - 1) tick();
        write_busy_i = 1'b0;
        tick();
        chk("lw_state", 32'(state_o), 5);
    endtask

    // Lock already synchronized high: DONE on the fourth qualifying edge.
    task automatic expect_done();
        repeat (3) tick();
        chk("pre_done_state", 32'(state_o), 5);
        chk("pre_done_flag", 32'(cfg_done_o), 0);
        tick();
        chk("done_state", 32'(state_o), 6);
        chk("done_flag", 32'(cfg_done_o), 1);
    endtask

    task automatic request();
        cfg_req_i = 1'b0;
        tick();
        tick();
        cfg_req_i = 1'b1;
        tick();
        tick();
        chk("req_state", 32'(state_o), 1);
        chk("req_retry", 32'(retry_cnt_o), 0);
        chk("req_err", 32'(cfg_err_o), 0);
        chk("req_done", 32'(cfg_done_o), 0);
    endtask

    task automatic expect_launch();
        repeat (9) tick();
        chk("pwr_start_low", 32'(spi_write_start_o), 0);
        chk("pwr_state", 32'(state_o), 1);
        tick();
        chk("launch_start", 32'(spi_write_start_o), 1);
        chk("launch_state", 32'(state_o), 2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int base;
        rst_i        = 1'b1;
        cfg_req_i    = 1'b0;
        write_busy_i = 1'b0;
        pll_ld_i     = 1'b1;
        repeat (3) tick();
        chk("rst_state", 32'(state_o), 1);
        chk("rst_start", 32'(spi_write_start_o), 0);
        chk("rst_done", 32'(cfg_done_o), 0);
        chk("rst_err", 32'(cfg_err_o), 0);
        chk("rst_lost", 32'(lock_lost_o), 0);
        chk("rst_retry", 32'(retry_cnt_o), 0);
        rst_i = 1'b0;

        // Nominal bring-up
        expect_launch();
        ack_write(20);
        expect_done();
        chk("nom_retry", 32'(retry_cnt_o), 0);

        // Lock loss in DONE, then requalification without an SPI rewrite
        pll_ld_i = 1'b0;
        tick();
        tick();
        chk("ll_still_done", 32'(state_o), 6);
        chk("ll_no_pulse_yet", 32'(lock_lost_o), 0);
        tick();
        chk("ll_pulse", 32'(lock_lost_o), 1);
        chk("ll_state", 32'(state_o), 5);
        chk("ll_done_low", 32'(cfg_done_o), 0);
        tick();
        chk("ll_pulse_end", 32'(lock_lost_o), 0);
        pll_ld_i = 1'b1;
        repeat (5) tick();
        chk("ll_relock_wait", 32'(state_o), 5);
        chk("ll_no_rewrite", 32'(spi_write_start_o), 0);
        tick();
        chk("ll_relock_done", 32'(state_o), 6);

        // Re-request from DONE, then no acknowledge on any attempt
        request();
        for (int a = 0; a < 3; a++) begin
            expect_launch();
            n = 1;
            for (int k = 0; k < 20 && spi_write_start_o; k++) begin
                tick();
                if (spi_write_start_o) n++;
            end
            chk("noack_start_len", 32'(n), 9);
            chk("noack_retry", 32'(retry_cnt_o), (a < 2) ? 32'(a + 1) : 32'd2);
            chk("noack_state", 32'(state_o), (a < 2) ? 32'd1 : 32'd7);
        end
        chk("err_flag", 32'(cfg_err_o), 1);
        repeat (15) tick();
        chk("err_hold_state", 32'(state_o), 7);
        chk("err_start_low", 32'(spi_write_start_o), 0);
        chk("err_hold_retry", 32'(retry_cnt_o), 2);

        // Re-request from ERROR; lock timeout on attempt 1, success on attempt 2
        request();
        base = start_rises;
        pll_ld_i = 1'b0;
        expect_launch();
        ack_write(3);
        repeat (49) tick();
        chk("lto_waiting", 32'(state_o), 5);
        tick();
        chk("lto_state", 32'(state_o), 1);
        chk("lto_retry", 32'(retry_cnt_o), 1);
        pll_ld_i = 1'b1;
        expect_launch();
        ack_write(3);
        expect_done();
        chk("lto_final_retry", 32'(retry_cnt_o), 1);
        chk("lto_start_rises", 32'(start_rises - base), 2);

        // Lock glitch during qualification restarts the stable count
        request();
        pll_ld_i = 1'b0;
        expect_launch();
        ack_write(3);
        pll_ld_i = 1'b1;
        repeat (3) tick();
        pll_ld_i = 1'b0;
        tick();
        pll_ld_i = 1'b1;
        tick();
        tick();
        chk("glitch_not_done", 32'(state_o), 5);
        repeat (3) tick();
        chk("glitch_still_wait", 32'(state_o), 5);
        tick();
        chk("glitch_done", 32'(state_o), 6);

        // Reset while WRITING aborts and the auto-start sequence repeats
        request();
        expect_launch();
        tick();
        tick();
        write_busy_i = 1'b1;
        tick();
        chk("rw_writing", 32'(state_o), 4);
        rst_i = 1'b1;
        tick();
        chk("rw_state", 32'(state_o), 1);
        chk("rw_start", 32'(spi_write_start_o), 0);
        chk("rw_done", 32'(cfg_done_o), 0);
        chk("rw_retry", 32'(retry_cnt_o), 0);
        rst_i = 1'b0;
        write_busy_i = 1'b0;
        expect_launch();
        ack_write(3);
        expect_done();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
